mmul_word_serial: RTL and testbench

//  Parametrised radix-2 Montgomery multiplier: result = A*B*2^-N mod P.

---
 rtl/mmul_pkg.sv | 27 ++
 rtl/mmul_slice_addsub.sv | 22 ++
 rtl/mmul_word_serial.sv | 152 +++++++++++++++
 tb/tb_mmul_word_serial.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mmul_pkg.sv
// rtl/mmul_pkg.sv - state encoding and sizing helpers for the word-serial Montgomery multiplier
package mmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIT,
    S_ADD_B,
    S_ADD_P,
    S_SHIFT,
    S_SUB,
    S_DONE
  } state_t;

  function automatic int unsigned ns_of(input int unsigned n, input int unsigned w);
    return n / w;
  endfunction

  function automatic int unsigned clog2_of(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mmul_slice_addsub.sv
// rtl/mmul_slice_addsub.sv - W-bit slice adder/subtractor with carry (add) or borrow (sub) chaining
module mmul_slice_addsub #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         sub_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] y_eff;
  logic [W:0]   total;

  // Subtract as x + ~y + ~bw; the carry out is then the inverted borrow.
  assign y_eff  = sub_i ? ~y_i : y_i;
  assign total  = {1'b0, x_i} + {1'b0, y_eff} + {{W{1'b0}}, cin_i ^ sub_i};
  assign sum_o  = total[W-1:0];
  assign cout_o = total[W] ^ sub_i;

endmodule

// File: rtl/mmul_word_serial.sv
// rtl/mmul_word_serial.sv - radix-2 Montgomery multiplier A*B*2^-N mod P, word-serial datapath
module mmul_word_serial
  import mmul_pkg::*;
#(
  parameter int N = 256,
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         clear_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] p_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [N-1:0] result_o
);

  localparam int unsigned NS = ns_of(N, W);
  localparam int unsigned SW = clog2_of(NS);
  localparam int unsigned BW = clog2_of(N);
  localparam logic [SW-1:0] LAST_SLICE = SW'(NS - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(N - 1);

  state_t          state_q;
  logic [N-1:0]    a_q, b_q, p_q, c_q, result_q;
  logic [N-W-1:0]  d_q;
  logic [1:0]      c_hi_q;
  logic [BW-1:0]   bit_cnt_q;
  logic [SW-1:0]   slice_cnt_q;
  logic            q_q, cy_q, busy_q, done_q, err_q;

  logic [W-1:0]    c_slice, y_slice, sum;
  logic            sub, cin, cout, last_slice, q_new, net_borrow;

  always_comb begin
    c_slice = c_q[slice_cnt_q*W +: W];
    y_slice = (state_q == S_ADD_B) ? b_q[slice_cnt_q*W +: W] : p_q[slice_cnt_q*W +: W];
  end

  assign sub        = (state_q == S_SUB);
  assign cin        = (slice_cnt_q == '0) ? 1'b0 : cy_q;
  assign last_slice = (slice_cnt_q == LAST_SLICE);
  assign q_new      = c_q[0] ^ (a_q[0] & b_q[0]);
  // {c_hi,C} < 2P keeps c_hi at 0 or 1, so a final borrow only matters when c_hi is 0.
  assign net_borrow = cout & (c_hi_q == 2'd0);

  mmul_slice_addsub #(.W(W)) u_addsub (
    .x_i   (c_slice),
    .y_i   (y_slice),
    .sub_i (sub),
    .cin_i (cin),
    .sum_o (sum),
    .cout_o(cout)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      c_hi_q      <= '0;
      bit_cnt_q   <= '0;
      slice_cnt_q <= '0;
      q_q         <= 1'b0;
      cy_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (clear_i) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        slice_cnt_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              if (p_i[0]) begin
                a_q         <= a_i;
                b_q         <= b_i;
                p_q         <= p_i;
                c_q         <= '0;
                c_hi_q      <= '0;
                bit_cnt_q   <= '0;
                slice_cnt_q <= '0;
                busy_q      <= 1'b1;
                state_q     <= S_BIT;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_BIT: begin
            q_q     <= q_new;
            state_q <= a_q[0] ? S_ADD_B : (q_new ? S_ADD_P : S_SHIFT);
          end
          S_ADD_B, S_ADD_P: begin
            c_q[slice_cnt_q*W +: W] <= sum;
            cy_q <= cout;
            if (last_slice) begin
              slice_cnt_q <= '0;
              c_hi_q      <= c_hi_q + {1'b0, cout};
              state_q     <= (state_q == S_ADD_B && q_q) ? S_ADD_P : S_SHIFT;
            end else begin
              slice_cnt_q <= slice_cnt_q + 1'b1;
            end
          end
          S_SHIFT: begin
            c_hi_q    <= {1'b0, c_hi_q[1]};
            c_q       <= {c_hi_q[0], c_q[N-1:1]};
            a_q       <= a_q >> 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            state_q   <= (bit_cnt_q == LAST_BIT) ? S_SUB : S_BIT;
          end
          S_SUB: begin
            cy_q <= cout;
            // The top slice of D goes straight into the result so it is valid with done.
            if (last_slice) begin
              slice_cnt_q <= '0;
              result_q    <= net_borrow ? c_q : {sum, d_q};
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              d_q[slice_cnt_q*W +: W] <= sum;
              slice_cnt_q <= slice_cnt_q + 1'b1;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mmul_word_serial.sv
// tb/tb_mmul_word_serial.sv - directed vector bench for mmul_word_serial at N=8, W=4
module tb_mmul_word_serial;

  logic       clk = 1'b0;
  logic       rst_n, start, clear;
  logic [7:0] a_in, b_in, p_in, result;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  mmul_word_serial #(.N(8), .W(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .clear_i (clear),
    .a_i     (a_in),
    .b_i     (b_in),
    .p_i     (p_in),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Launch one operation; lat is the index of the cycle after the accept edge in which done is seen (0 on timeout).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p,
                        input int hold_lo, input int hold_hi,
                        output logic [7:0] res, output int lat, output int busy_low);
    @(negedge clk);
    a_in = a; b_in = b; p_in = p; start = 1'b1;
    @(posedge clk);
    lat = 0; busy_low = 0; res = 8'h00;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      a_in = 8'h5A; b_in = 8'hA5; p_in = 8'hF1;
      start = (n >= hold_lo && n <= hold_hi);
      if (!busy) busy_low++;
      if (done) begin
        lat = n;
        res = result;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] res, prev;
    int lat, busy_low, dones;

    vecs[0] = '{8'h01, 8'h01, 8'hF1, 8'hE1};
    vecs[1] = '{8'h0F, 8'h07, 8'hF1, 8'h07};
    vecs[2] = '{8'h00, 8'h55, 8'hF1, 8'h00};
    vecs[3] = '{8'hF0, 8'hF0, 8'hF1, 8'hE1};
    vecs[4] = '{8'h10, 8'h10, 8'hF1, 8'h01};
    vecs[5] = '{8'hF0, 8'h01, 8'hF1, 8'h10};
    vecs[6] = '{8'h02, 8'h03, 8'h0D, 8'h05};
    vecs[7] = '{8'h0C, 8'h0C, 8'h0D, 8'h03};

    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    a_in = '0; b_in = '0; p_in = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_result", result, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, 1, 0, res, lat, busy_low);
      check($sformatf("vec%0d_finished", i), lat > 0, 1);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_busy_held", i), busy_low, 0);
      if (vecs[i].a == 8'h00) check($sformatf("vec%0d_latency", i), lat, 19);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), done, 0);
      check($sformatf("vec%0d_busy_after", i), busy, 0);
    end

    // Even modulus: err pulse, no operation, result untouched.
    prev = result;
    p_in = 8'hF0; a_in = 8'h01; b_in = 8'h01; start = 1'b1;
    @(negedge clk);
    check("even_p_err", err, 1);
    check("even_p_busy", busy, 0);
    start = 1'b0;
    @(negedge clk);
    check("even_p_err_pulse", err, 0);
    check("even_p_result", result, prev);

    // Clear in the first ADD_P cycle of case 1 (BIT, ADD_B x2, ADD_P), together with start.
    prev = result;
    a_in = 8'h01; b_in = 8'h01; p_in = 8'hF1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check("clear_busy", busy, 0);
    check("clear_done", done, 0);
    check("clear_result", result, prev);
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("clear_no_activity", dones, 0);
    run_op(8'h0F, 8'h07, 8'hF1, 1, 0, res, lat, busy_low);
    check("after_clear_result", res, 8'h07);

    // Start held high while busy must not disturb or restart the operation.
    run_op(8'h00, 8'h55, 8'hF1, 2, 10, res, lat, busy_low);
    check("start_busy_result", res, 8'h00);
    check("start_busy_latency", lat, 19);
    @(negedge clk);
    check("start_busy_idle", busy, 0);

    run_op(8'h0F, 8'h07, 8'hF1, 1, 0, res, lat, busy_low);
    check("pre_reset_result", res, 8'h07);

    // Reset in the first SUB cycle of an A=0 run (cycles 17 and 18).
    @(negedge clk);
    a_in = 8'h00; b_in = 8'h55; p_in = 8'hF1; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      start = (n >= 3 && n <= 6);
    end
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_stays_idle", busy, 0);

    run_op(8'h01, 8'h01, 8'hF1, 1, 0, res, lat, busy_low);
    check("post_reset_result", res, 8'hE1);
    check("post_reset_finished", lat > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
